uart_baud_gen_frac: RTL and testbench

Parametrised baud/oversample tick generator for the UART subsystem, successor to the fixed-divide 115200 tick source. It produces a one-clock oversample strobe at a runtime-programmable fractional divide ratio, plus bit-rate and mid-bit strobes derived from it. The UART TX block consumes `bit_tick`; the RX block consumes `os_tick` and `mid_tick` and uses `resync` to align phase to the start-bit edge.

---
 rtl/uart_baud_gen_frac.sv | 109 ++++++++++
 tb/tb_uart_baud_gen_frac.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N oversample tick generator for the UART: os_tick at eff + a_frac/2^FRAC_W clocks,
// with bit-rate and mid-bit strobes derived from an oversample counter.
module uart_baud_gen_frac #(
   parameter int                 DIV_W            = 16,
   parameter int                 FRAC_W           = 8,
   parameter int                 OVERSAMPLE       = 16,
   parameter logic [DIV_W-1:0]   DEFAULT_DIV_INT  = DIV_W'(27),
   parameter logic [FRAC_W-1:0]  DEFAULT_DIV_FRAC = FRAC_W'(0)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   input  logic              resync,
   output logic              os_tick,
   output logic              bit_tick,
   output logic              mid_tick,
   output logic              div_pending
);

   localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   logic [DIV_W-1:0]  cnt;
   logic [FRAC_W-1:0] acc;
   logic              long_p;
   logic [OS_W-1:0]   os_cnt;
   logic [DIV_W-1:0]  a_int;
   logic [FRAC_W-1:0] a_frac;
   logic [DIV_W-1:0]  s_int;
   logic [FRAC_W-1:0] s_frac;
   logic              pend;

   logic [DIV_W-1:0]  eff;
   logic [DIV_W:0]    period_m1;
   logic              apply;
   logic              os_wrap;
   logic [FRAC_W:0]   acc_sum;

   // Divisors below 2 would make the period degenerate, so they clamp to 2.
   assign eff       = (a_int < DIV_W'(2)) ? DIV_W'(2) : a_int;
   assign period_m1 = {1'b0, eff} + (DIV_W+1)'(long_p) - (DIV_W+1)'(1);
   assign acc_sum   = {1'b0, acc} + {1'b0, a_frac};
   assign os_wrap   = (os_cnt == OS_W'(OVERSAMPLE-1));

   // A resync cycle restarts the phase, so it never produces a strobe itself.
   assign os_tick     = en & ~resync & ({1'b0, cnt} == period_m1);
   assign bit_tick    = os_tick & os_wrap;
   assign mid_tick    = os_tick & (os_cnt == OS_W'(OVERSAMPLE/2-1));
   assign div_pending = pend;

   // A pending divisor lands on a period boundary, immediately when stalled, or on resync.
   assign apply = pend & (os_tick | ~en | resync);

   // Shadow/active divisor registers; resync with a fresh load bypasses the shadow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_int  <= DEFAULT_DIV_INT;
         s_frac <= DEFAULT_DIV_FRAC;
         a_int  <= DEFAULT_DIV_INT;
         a_frac <= DEFAULT_DIV_FRAC;
         pend   <= 1'b0;
      end else begin
         if (div_load) begin
            s_int  <= div_int;
            s_frac <= div_frac;
         end
         if (resync && div_load) begin
            a_int  <= div_int;
            a_frac <= div_frac;
         end else if (apply) begin
            a_int  <= s_int;
            a_frac <= s_frac;
         end
         if (div_load)
            pend <= ~resync;
         else if (apply)
            pend <= 1'b0;
      end
   end

   // Period counter, fractional accumulator and oversample counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         acc    <= '0;
         long_p <= 1'b0;
         os_cnt <= '0;
      end else if (resync) begin
         cnt    <= '0;
         acc    <= '0;
         long_p <= 1'b0;
         os_cnt <= '0;
      end else if (os_tick) begin
         cnt <= '0;
         if (apply) begin
            acc    <= '0;
            long_p <= 1'b0;
         end else begin
            {long_p, acc} <= acc_sum;
         end
         os_cnt <= os_wrap ? '0 : os_cnt + OS_W'(1);
      end else if (en) begin
         cnt <= cnt + DIV_W'(1);
      end
   end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed self-checking bench for uart_baud_gen_frac: tick spacing, fractional
// averaging, divisor load/apply, resync, enable gating, clamping and async reset.
module tb_uart_baud_gen_frac;

   logic        clk;
   logic        reset_n;
   logic        en;
   logic [15:0] div_int;
   logic [7:0]  div_frac;
   logic        div_load;
   logic        resync;
   logic        os_tick;
   logic        bit_tick;
   logic        mid_tick;
   logic        div_pending;

   int checks   = 0;
   int failures = 0;

   uart_baud_gen_frac dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .div_int     (div_int),
      .div_frac    (div_frac),
      .div_load    (div_load),
      .resync      (resync),
      .os_tick     (os_tick),
      .bit_tick    (bit_tick),
      .mid_tick    (mid_tick),
      .div_pending (div_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic ld, input int di, input int df,
                                input logic rs);
      en       = e;
      div_load = ld;
      div_int  = 16'(di);
      div_frac = 8'(df);
      resync   = rs;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts cycles from the current one up to and including the next os_tick cycle.
   task automatic waitTick(input string tag, input int budget, output int gap,
                           output int mid, output int bt);
      bit done;
      gap  = 0;
      mid  = 0;
      bt   = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         gap++;
         if (os_tick) begin
            mid  = int'(mid_tick);
            bt   = int'(bit_tick);
            done = 1;
         end else if (gap >= budget) begin
            checkOutput({tag, "_tick_seen"}, 0, 1);
            gap  = -1;
            done = 1;
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Strobe-shape invariants, checked every cycle.
   always @(negedge clk) begin
      checkOutput("strobe_without_os", int'((bit_tick | mid_tick) & ~os_tick), 0);
      checkOutput("tick_while_disabled", int'(os_tick & ~en), 0);
   end

   initial begin
      int gap, mid, bt, sum;

      reset_n = 1'b0;
      applyStimulus(1, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_os", int'(os_tick), 0);
      checkOutput("rst_bit", int'(bit_tick), 0);
      checkOutput("rst_mid", int'(mid_tick), 0);
      checkOutput("rst_pend", int'(div_pending), 0);
      reset_n = 1'b1;

      // Default divide of 27, mid on the 8th tick, bit on the 16th.
      for (int i = 1; i <= 16; i++) begin
         waitTick("def", 60, gap, mid, bt);
         checkOutput($sformatf("def_gap%0d", i), gap, 27);
         checkOutput($sformatf("def_mid%0d", i), mid, (i == 8) ? 1 : 0);
         checkOutput($sformatf("def_bit%0d", i), bt, (i == 16) ? 1 : 0);
      end
      sum = 0;
      for (int i = 1; i <= 16; i++) begin
         waitTick("def2", 60, gap, mid, bt);
         sum += gap;
      end
      checkOutput("def_bit_span", sum, 432);
      checkOutput("def_bit_last", bt, 1);

      // Loads mid-period: old period completes, last load wins.
      idle(5);
      applyStimulus(1, 1, 9, 0, 0);
      idle(1);
      applyStimulus(1, 1, 5, 0, 0);
      idle(1);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("ld_pend_high", int'(div_pending), 1);
      waitTick("ld_old", 60, gap, mid, bt);
      checkOutput("ld_old_gap", gap, 20);
      checkOutput("ld_pend_low", int'(div_pending), 0);
      for (int i = 1; i <= 3; i++) begin
         waitTick("ld_new", 60, gap, mid, bt);
         checkOutput($sformatf("ld_new_gap%0d", i), gap, 5);
      end

      // Fractional divide 10 + 0x80/256.
      applyStimulus(1, 1, 10, 8'h80, 0);
      idle(1);
      applyStimulus(1, 0, 0, 0, 0);
      waitTick("frac_apply", 60, gap, mid, bt);
      checkOutput("frac_apply_gap", gap, 4);
      waitTick("frac_first", 60, gap, mid, bt);
      checkOutput("frac_first_gap", gap, 10);
      sum = 0;
      for (int i = 1; i <= 256; i++) begin
         waitTick("frac", 60, gap, mid, bt);
         if (i == 1) checkOutput("frac_gap_a", gap, 10);
         if (i == 2) checkOutput("frac_gap_b", gap, 11);
         sum += gap;
      end
      checkOutput("frac_span256", sum, 2688);

      // Resync with a simultaneous load applies div 12 immediately.
      applyStimulus(1, 1, 12, 0, 1);
      idle(1);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("rs_ld_pend", int'(div_pending), 0);
      for (int i = 1; i <= 9; i++) begin
         waitTick("rs_pre", 60, gap, mid, bt);
         checkOutput($sformatf("rs_pre_gap%0d", i), gap, 12);
      end
      // Now at os_cnt 9; resync lands on what would be a tick cycle.
      idle(11);
      applyStimulus(1, 0, 0, 0, 1);
      #1;
      checkOutput("rs_no_tick", int'(os_tick), 0);
      idle(1);
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         waitTick("rs_post", 60, gap, mid, bt);
         checkOutput($sformatf("rs_post_gap%0d", i), gap, 12);
         checkOutput($sformatf("rs_post_mid%0d", i), mid, (i == 8) ? 1 : 0);
      end

      // Resync while disabled clears the partially elapsed period.
      idle(4);
      applyStimulus(0, 0, 0, 0, 0);
      idle(3);
      applyStimulus(0, 0, 0, 0, 1);
      idle(1);
      applyStimulus(0, 0, 0, 0, 0);
      idle(5);
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         waitTick("rs_dis", 60, gap, mid, bt);
         checkOutput($sformatf("rs_dis_gap%0d", i), gap, 12);
         checkOutput($sformatf("rs_dis_mid%0d", i), mid, (i == 8) ? 1 : 0);
      end

      // Enable dropped for 7 cycles right on a tick cycle.
      idle(11);
      applyStimulus(0, 0, 0, 0, 0);
      #1;
      checkOutput("gate_suppressed", int'(os_tick), 0);
      idle(7);
      applyStimulus(1, 0, 0, 0, 0);
      waitTick("gate_resume", 60, gap, mid, bt);
      checkOutput("gate_resume_gap", gap, 1);
      waitTick("gate_next", 60, gap, mid, bt);
      checkOutput("gate_next_gap", gap, 12);

      // Divisor 0 loaded while disabled applies the following cycle, clamped to 2.
      applyStimulus(0, 1, 0, 0, 0);
      idle(1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("clamp0_pend_high", int'(div_pending), 1);
      idle(1);
      checkOutput("clamp0_pend_low", int'(div_pending), 0);
      applyStimulus(0, 0, 0, 0, 1);
      idle(1);
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         waitTick("clamp0", 60, gap, mid, bt);
         checkOutput($sformatf("clamp0_gap%0d", i), gap, 2);
      end
      applyStimulus(1, 1, 1, 0, 1);
      idle(1);
      applyStimulus(1, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         waitTick("clamp1", 60, gap, mid, bt);
         checkOutput($sformatf("clamp1_gap%0d", i), gap, 2);
      end

      // Async reset on a tick cycle with a load pending.
      applyStimulus(1, 1, 40, 0, 0);
      idle(1);
      applyStimulus(1, 0, 0, 0, 0);
      #1;
      checkOutput("arst_pre_os", int'(os_tick), 1);
      checkOutput("arst_pre_pend", int'(div_pending), 1);
      reset_n = 1'b0;
      #1;
      checkOutput("arst_os", int'(os_tick), 0);
      checkOutput("arst_pend", int'(div_pending), 0);
      idle(2);
      reset_n = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         waitTick("arst", 80, gap, mid, bt);
         checkOutput($sformatf("arst_gap%0d", i), gap, 27);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
